// File: rtl/pifo_flow_queues.sv
// rtl/pifo_flow_queues.sv - per-flow descriptor FIFOs feeding pifo_set; optional stats via PIFO_FLOW_QUEUES_STATS_EN
module pifo_flow_queues #(
    parameter int NUM_FLOWS    = 16,
    parameter int QDEPTH       = 8,
    parameter int MAX_PRIORITY = 256,
    parameter int DESC_WIDTH   = 32,
    localparam int FLOW_WIDTH  = $clog2(NUM_FLOWS),
    localparam int PRIO_WIDTH  = $clog2(MAX_PRIORITY)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i__pkt_valid,
    input  logic [FLOW_WIDTH-1:0] i__pkt_flow_id,
    input  logic [PRIO_WIDTH-1:0] i__pkt_rank,
    input  logic [DESC_WIDTH-1:0] i__pkt_desc,
    output logic                  o__pkt_ready,
    output logic                  o__push_valid,
    output logic [PRIO_WIDTH-1:0] o__push_priority,
    output logic [FLOW_WIDTH-1:0] o__push_flow_id,
    input  logic                  i__pifo_set_ready,
    input  logic                  i__pop_valid,
    input  logic [FLOW_WIDTH-1:0] i__pop_flow_id,
    output logic                  o__pop,
    output logic                  o__reinsert_valid,
    output logic [PRIO_WIDTH-1:0] o__reinsert_priority,
    output logic                  o__deq_valid,
    output logic [FLOW_WIDTH-1:0] o__deq_flow_id,
    output logic [DESC_WIDTH-1:0] o__deq_desc,
    input  logic                  i__deq_ready,
    input  logic                  i__clear_all
`ifdef PIFO_FLOW_QUEUES_STATS_EN
    ,
    output logic [31:0]           o__stat_enq_count,
    output logic [31:0]           o__stat_deq_count,
    output logic [$clog2(NUM_FLOWS*QDEPTH+1)-1:0] o__stat_occupancy
`endif
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(QDEPTH);
    localparam logic [PRIO_WIDTH-1:0] PRIO_ONE = PRIO_WIDTH'(1);

    // Descriptor storage is never reset; only pointers and counts are.
    logic [PRIO_WIDTH-1:0] mem_rank [NUM_FLOWS][QDEPTH];
    logic [DESC_WIDTH-1:0] mem_desc [NUM_FLOWS][QDEPTH];
    logic [PTR_W-1:0]      rd_ptr   [NUM_FLOWS];
    logic [PTR_W-1:0]      wr_ptr   [NUM_FLOWS];
    logic [CNT_W-1:0]      count    [NUM_FLOWS];
    logic [NUM_FLOWS-1:0]  active;

    logic [FLOW_WIDTH-1:0] f;
    logic [FLOW_WIDTH-1:0] p;
    logic [PRIO_WIDTH-1:0] rank_eff;
    logic                  accept;
    logic                  deq_fire;
    logic [PTR_W-1:0]      next_head;
    logic                  reinsert_sel;
    logic [PRIO_WIDTH-1:0] reinsert_rank;
    logic [NUM_FLOWS-1:0]  enq_hit;
    logic [NUM_FLOWS-1:0]  deq_hit;

    assign f         = i__pkt_flow_id;
    assign p         = i__pop_flow_id;
    // Rank 0 is reserved to mean "no reinsert", so it is promoted to 1.
    assign rank_eff  = (i__pkt_rank == '0) ? PRIO_ONE : i__pkt_rank;

    // An idle flow needs room in pifo_set; an active flow only needs FIFO room.
    assign o__pkt_ready = ~reset & ~i__clear_all & (count[f] < CNT_FULL)
                        & (active[f] | i__pifo_set_ready);
    assign accept       = i__pkt_valid & o__pkt_ready;

    assign o__push_valid    = accept & ~active[f];
    assign o__push_priority = rank_eff;
    assign o__push_flow_id  = f;

    assign o__deq_valid   = i__pop_valid & ~reset;
    assign o__deq_flow_id = p;
    assign o__deq_desc    = mem_desc[p][rd_ptr[p]];
    assign o__pop         = o__deq_valid & i__deq_ready;
    assign deq_fire       = o__pop;
    assign next_head      = rd_ptr[p] + PTR_ONE;

    // Pick the rank that keeps the popped flow in pifo_set, if it stays backlogged.
    always_comb begin
        reinsert_sel  = 1'b0;
        reinsert_rank = '0;
        if (deq_fire) begin
            if (count[p] >= CNT_TWO) begin
                reinsert_sel  = 1'b1;
                reinsert_rank = mem_rank[p][next_head];
            end else if (count[p] == CNT_ONE && accept && f == p) begin
                reinsert_sel  = 1'b1;
                reinsert_rank = rank_eff;
            end
        end
    end

    assign o__reinsert_valid    = reinsert_sel;
    assign o__reinsert_priority = reinsert_rank;

    // One-hot per-flow enqueue/dequeue strobes for the state update.
    always_comb begin
        enq_hit = '0;
        deq_hit = '0;
        if (accept) begin
            enq_hit[f] = 1'b1;
        end
        if (deq_fire) begin
            deq_hit[p] = 1'b1;
        end
    end

    // Write accepted packets at the tail of their flow.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_rank[f][wr_ptr[f]] <= rank_eff;
            mem_desc[f][wr_ptr[f]] <= i__pkt_desc;
        end
    end

    // Pointers, counts and active bits; clear_all discards same-cycle traffic.
    always_ff @(posedge clk) begin
        if (reset || i__clear_all) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            active <= '0;
        end else begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (enq_hit[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                end
                if (deq_hit[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                end
                case ({enq_hit[i], deq_hit[i]})
                    2'b10:   count[i] <= count[i] + CNT_ONE;
                    2'b01:   count[i] <= count[i] - CNT_ONE;
                    default: count[i] <= count[i];
                endcase
                if (enq_hit[i] && !active[i]) begin
                    active[i] <= 1'b1;
                end else if (deq_hit[i] && !reinsert_sel) begin
                    active[i] <= 1'b0;
                end
            end
        end
    end

`ifdef PIFO_FLOW_QUEUES_STATS_EN
    localparam int OCC_W = $clog2(NUM_FLOWS * QDEPTH + 1);

    logic [OCC_W-1:0] occupancy;

    // Total buffered packets across all flows.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            occupancy = occupancy + OCC_W'(count[i]);
        end
    end

    assign o__stat_occupancy = occupancy;

    // Saturating enqueue/dequeue event counters.
    always_ff @(posedge clk) begin
        if (reset || i__clear_all) begin
            o__stat_enq_count <= '0;
            o__stat_deq_count <= '0;
        end else begin
            if (accept && o__stat_enq_count != 32'hFFFF_FFFF) begin
                o__stat_enq_count <= o__stat_enq_count + 32'd1;
            end
            if (deq_fire && o__stat_deq_count != 32'hFFFF_FFFF) begin
                o__stat_deq_count <= o__stat_deq_count + 32'd1;
            end
        end
    end
`endif

    for (genvar g = 0; g < NUM_FLOWS; g++) begin : g_inv
        a_active_matches_count: assert property (
            @(posedge clk) disable iff (reset) active[g] == (count[g] != '0));
    end

    a_pop_only_active: assert property (
        @(posedge clk) disable iff (reset) i__pop_valid |-> active[i__pop_flow_id]);

endmodule
